// File: rtl/fizzbuzz_multi.sv
// fizzbuzz_multi: streams 1..G_LENGTH with one divisibility flag per channel
// over a valid/ready interface, in one-shot or continuous (wrapping) runs.
module fizzbuzz_multi #(
  parameter int unsigned G_LENGTH = 20,
  parameter int unsigned G_NUM_CH = 4,
  parameter int unsigned G_DIV_W  = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_en,
  input  logic                           i_mode,
  input  logic                           i_clr,
  input  logic [G_NUM_CH*G_DIV_W-1:0]    i_div,
  output logic                           o_valid,
  input  logic                           i_ready,
  output logic [$clog2(G_LENGTH+1)-1:0]  o_number,
  output logic [G_NUM_CH-1:0]            o_hit,
  output logic                           o_done,
  output logic                           o_busy
);

  localparam int unsigned NUM_W = $clog2(G_LENGTH + 1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                            state_q;
  state_t                            state_nxt;
  logic [G_NUM_CH-1:0][G_DIV_W-1:0]  div_q;
  logic [G_NUM_CH-1:0][G_DIV_W-1:0]  div_nxt;
  logic [G_NUM_CH-1:0][G_DIV_W-1:0]  cnt_q;
  logic [G_NUM_CH-1:0][G_DIV_W-1:0]  cnt_nxt;
  logic                              mode_q;
  logic                              mode_nxt;
  logic [NUM_W-1:0]                  number_nxt;
  logic [G_NUM_CH-1:0]               hit_nxt;
  logic                              done_nxt;
  logic                              xfer;
  logic                              last;

  assign xfer = o_valid && i_ready;
  assign last = (o_number == NUM_W'(G_LENGTH));

  // State, configuration and registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      cnt_q    <= '0;
      mode_q   <= 1'b0;
      o_valid  <= 1'b0;
      o_busy   <= 1'b0;
      o_number <= '0;
      o_hit    <= '0;
      o_done   <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      div_q    <= div_nxt;
      cnt_q    <= cnt_nxt;
      mode_q   <= mode_nxt;
      o_valid  <= (state_nxt == S_RUN);
      o_busy   <= (state_nxt == S_RUN);
      o_number <= number_nxt;
      o_hit    <= hit_nxt;
      o_done   <= done_nxt;
    end
  end

  // Next state; abort wins over start and over the final transfer
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_en && !i_clr) state_nxt = S_RUN;
      end
      S_RUN: begin
        if (i_clr) state_nxt = S_IDLE;
        else if (xfer && last && !mode_q) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Datapath: residue counters replace any modulo; a zero divisor freezes its channel
  always_comb begin
    div_nxt    = div_q;
    cnt_nxt    = cnt_q;
    mode_nxt   = mode_q;
    number_nxt = o_number;
    done_nxt   = 1'b0;
    hit_nxt    = '0;
    if (!i_clr) begin
      if (state_q == S_IDLE) begin
        if (i_en) begin
          mode_nxt   = i_mode;
          number_nxt = NUM_W'(1);
          for (int unsigned k = 0; k < G_NUM_CH; k++) begin
            div_nxt[k] = i_div[k*G_DIV_W +: G_DIV_W];
            cnt_nxt[k] = G_DIV_W'(1);
          end
        end
      end else if (xfer) begin
        if (!last) begin
          number_nxt = o_number + NUM_W'(1);
          for (int unsigned k = 0; k < G_NUM_CH; k++) begin
            if (div_q[k] != '0) begin
              cnt_nxt[k] = (cnt_q[k] == div_q[k]) ? G_DIV_W'(1) : cnt_q[k] + G_DIV_W'(1);
            end
          end
        end else if (mode_q) begin
          number_nxt = NUM_W'(1);
          for (int unsigned k = 0; k < G_NUM_CH; k++) begin
            cnt_nxt[k] = G_DIV_W'(1);
          end
        end else begin
          done_nxt = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < G_NUM_CH; k++) begin
      hit_nxt[k] = (div_nxt[k] != '0) && (cnt_nxt[k] == div_nxt[k]);
    end
  end

endmodule

// File: tb/tb_fizzbuzz_multi.sv
// Bench for fizzbuzz_multi: expected items queued at stimulus time and popped
// on every accepted transfer; per-scenario tasks check framing and control.
module tb_fizzbuzz_multi;

  localparam int unsigned LEN = 15;
  localparam int unsigned NCH = 4;
  localparam int unsigned DW  = 4;
  localparam int unsigned NW  = $clog2(LEN + 1);

  typedef struct packed {
    logic [NW-1:0]  num;
    logic [NCH-1:0] hit;
  } item_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              mode;
  logic              clr;
  logic [NCH*DW-1:0] div;
  logic              valid;
  logic              ready;
  logic [NW-1:0]     number;
  logic [NCH-1:0]    hit;
  logic              done;
  logic              busy;

  item_t exp_q[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    item_cnt;
  int    done_cnt;
  int    cyc;
  int    last_item_cyc;
  int    first_done_cyc;
  int    done_busy_overlap;

  fizzbuzz_multi #(
    .G_LENGTH(LEN),
    .G_NUM_CH(NCH),
    .G_DIV_W (DW)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_en    (en),
    .i_mode  (mode),
    .i_clr   (clr),
    .i_div   (div),
    .o_valid (valid),
    .i_ready (ready),
    .o_number(number),
    .o_hit   (hit),
    .o_done  (done),
    .o_busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH-1:0] model_hit(input int n, input logic [NCH*DW-1:0] d);
    logic [NCH-1:0] h;
    int dk;
    h = '0;
    for (int k = 0; k < NCH; k++) begin
      dk = int'(d[k*DW +: DW]);
      h[k] = (dk != 0) && ((n % dk) == 0);
    end
    return h;
  endfunction

  task automatic push_range(input int lo, input int hi, input logic [NCH*DW-1:0] d);
    item_t it;
    for (int n = lo; n <= hi; n++) begin
      it.num = NW'(n);
      it.hit = model_hit(n, d);
      exp_q.push_back(it);
    end
  endtask

  task automatic clear_stats();
    exp_q.delete();
    item_cnt = 0;
    done_cnt = 0;
    cyc = 0;
    last_item_cyc = -1;
    first_done_cyc = -1;
    done_busy_overlap = 0;
  endtask

  // One clock: score an accepted item at negedge, then return 1 time unit after posedge
  task automatic sb_cycle(input string tag);
    item_t e;
    @(negedge clk);
    if (valid && ready) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL %s_extra: got number=%0d hit=%b, required no item", tag, number, hit);
      end else begin
        e = exp_q.pop_front();
        if ({number, hit} !== {e.num, e.hit}) begin
          n_fail++;
          $display("FAIL %s_item: got number=%0d hit=%b, required number=%0d hit=%b",
                   tag, number, hit, e.num, e.hit);
        end
      end
      item_cnt++;
      last_item_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      if (first_done_cyc < 0) first_done_cyc = cyc;
      if (busy) done_busy_overlap++;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_run(input logic [NCH*DW-1:0] d, input logic m);
    div  = d;
    mode = m;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    clear_stats();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    clr   = 1'b0;
    mode  = 1'b0;
    ready = 1'b0;
    div   = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b, required 0", valid); end
    n_tests++; if (number !== '0) begin n_fail++; $display("FAIL reset_number: got %0d, required 0", number); end
    n_tests++; if (hit !== '0) begin n_fail++; $display("FAIL reset_hit: got %b, required 0", hit); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b, required 0", done); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b, required 0", busy); end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_oneshot();
    logic [NCH*DW-1:0] d;
    d = {4'd0, 4'd15, 4'd5, 4'd3};
    ready = 1'b1;
    start_run(d, 1'b0);
    push_range(1, 15, d);
    repeat (20) sb_cycle("oneshot");
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL oneshot_count: got %0d, required 15", item_cnt); end
    n_tests++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL oneshot_left: got %0d, required 0", exp_q.size()); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL oneshot_done_cnt: got %0d, required 1", done_cnt); end
    n_tests++; if (first_done_cyc !== 15) begin n_fail++; $display("FAIL oneshot_done_cyc: got %0d, required 15", first_done_cyc); end
    n_tests++; if (last_item_cyc !== 14) begin n_fail++; $display("FAIL oneshot_last_cyc: got %0d, required 14", last_item_cyc); end
    n_tests++; if (done_busy_overlap !== 0) begin n_fail++; $display("FAIL oneshot_done_busy: got %0d, required 0", done_busy_overlap); end
  endtask

  task automatic test_backpressure();
    logic [NCH*DW-1:0] d;
    logic [NCH-1:0]    held_hit;
    int stall;
    d = {4'd0, 4'd0, 4'd5, 4'd3};
    held_hit = model_hit(4, d);
    stall = 0;
    ready = 1'b1;
    start_run(d, 1'b0);
    push_range(1, 15, d);
    for (int i = 0; i < 25; i++) begin
      if (stall < 3 && (stall > 0 || number === NW'(4))) begin
        ready = 1'b0;
        stall++;
        n_tests++;
        if ({valid, number, hit} !== {1'b1, NW'(4), held_hit}) begin
          n_fail++;
          $display("FAIL bp_hold: got valid=%b number=%0d hit=%b, required valid=1 number=4 hit=%b",
                   valid, number, hit, held_hit);
        end
      end else begin
        ready = 1'b1;
      end
      sb_cycle("bp");
    end
    n_tests++; if (stall !== 3) begin n_fail++; $display("FAIL bp_stalls: got %0d, required 3", stall); end
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL bp_count: got %0d, required 15", item_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL bp_done_cnt: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_continuous();
    logic [NCH*DW-1:0] d;
    d = {4'd0, 4'd1, 4'd7, 4'd4};
    ready = 1'b1;
    start_run(d, 1'b1);
    push_range(1, 15, d);
    push_range(1, 15, d);
    push_range(1, 5, d);
    repeat (35) sb_cycle("cont");
    n_tests++; if (item_cnt !== 35) begin n_fail++; $display("FAIL cont_count: got %0d, required 35", item_cnt); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL cont_done: got %0d, required 0", done_cnt); end
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL cont_busy: got %b, required 1", busy); end
    clr   = 1'b1;
    ready = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    n_tests++;
    if ({valid, busy, done} !== 3'b000) begin
      n_fail++;
      $display("FAIL cont_stop: got valid=%b busy=%b done=%b, required 0 0 0", valid, busy, done);
    end
  endtask

  task automatic test_div1_2();
    logic [NCH*DW-1:0] d;
    d = {4'd0, 4'd0, 4'd2, 4'd1};
    ready = 1'b1;
    start_run(d, 1'b0);
    push_range(1, 15, d);
    repeat (20) sb_cycle("div12");
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL div12_count: got %0d, required 15", item_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL div12_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_cfg_change();
    logic [NCH*DW-1:0] d0;
    logic [NCH*DW-1:0] d7;
    logic toggled;
    d0 = {4'd0, 4'd0, 4'd5, 4'd3};
    d7 = {4'd7, 4'd7, 4'd7, 4'd7};
    toggled = 1'b0;
    ready = 1'b1;
    start_run(d0, 1'b0);
    push_range(1, 15, d0);
    for (int i = 0; i < 20; i++) begin
      if (!toggled && number === NW'(5)) begin
        div  = d7;
        mode = 1'b1;
        en   = 1'b1;
        toggled = 1'b1;
      end else begin
        en = 1'b0;
      end
      sb_cycle("cfg1");
    end
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL cfg1_count: got %0d, required 15", item_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL cfg1_done: got %0d, required 1", done_cnt); end
    start_run(d7, 1'b0);
    push_range(1, 15, d7);
    repeat (20) sb_cycle("cfg2");
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL cfg2_count: got %0d, required 15", item_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL cfg2_done: got %0d, required 1", done_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [NCH*DW-1:0] d;
    d = {4'd0, 4'd0, 4'd5, 4'd3};
    ready = 1'b1;
    div   = d;
    mode  = 1'b0;
    en    = 1'b1;
    @(posedge clk);
    #1;
    clear_stats();
    push_range(1, 15, d);
    push_range(1, 15, d);
    for (int i = 0; i < 33; i++) begin
      if (i == 17) en = 1'b0;
      sb_cycle("b2b");
    end
    n_tests++; if (item_cnt !== 30) begin n_fail++; $display("FAIL b2b_count: got %0d, required 30", item_cnt); end
    n_tests++; if (done_cnt !== 2) begin n_fail++; $display("FAIL b2b_done: got %0d, required 2", done_cnt); end
    n_tests++; if (first_done_cyc !== 15) begin n_fail++; $display("FAIL b2b_done_cyc: got %0d, required 15", first_done_cyc); end
  endtask

  task automatic test_abort();
    logic [NCH*DW-1:0] d;
    logic hit9;
    d = {4'd0, 4'd0, 4'd5, 4'd3};
    ready = 1'b1;
    start_run(d, 1'b0);
    push_range(1, 9, d);
    hit9 = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (!hit9 && number === NW'(9)) begin
        clr  = 1'b1;
        hit9 = 1'b1;
        sb_cycle("abort");
        clr = 1'b0;
        n_tests++;
        if ({valid, done, busy} !== 3'b000) begin
          n_fail++;
          $display("FAIL abort_idle: got valid=%b done=%b busy=%b, required 0 0 0", valid, done, busy);
        end
      end else begin
        sb_cycle("abort");
      end
    end
    n_tests++; if (item_cnt !== 9) begin n_fail++; $display("FAIL abort_count: got %0d, required 9", item_cnt); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL abort_done: got %0d, required 0", done_cnt); end

    start_run(d, 1'b0);
    push_range(1, 9, d);
    hit9 = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (!hit9 && number === NW'(9)) begin
        rst_n = 1'b0;
        hit9  = 1'b1;
        sb_cycle("rst");
        rst_n = 1'b1;
        n_tests++;
        if ({valid, number, hit, done, busy} !== '0) begin
          n_fail++;
          $display("FAIL rst_outputs: got valid=%b number=%0d hit=%b done=%b busy=%b, required all 0",
                   valid, number, hit, done, busy);
        end
      end else begin
        sb_cycle("rst");
      end
    end
    n_tests++; if (item_cnt !== 9) begin n_fail++; $display("FAIL rst_count: got %0d, required 9", item_cnt); end
    n_tests++; if (done_cnt !== 0) begin n_fail++; $display("FAIL rst_done: got %0d, required 0", done_cnt); end

    start_run(d, 1'b0);
    push_range(1, 15, d);
    repeat (20) sb_cycle("restart");
    n_tests++; if (item_cnt !== 15) begin n_fail++; $display("FAIL restart_count: got %0d, required 15", item_cnt); end
    n_tests++; if (done_cnt !== 1) begin n_fail++; $display("FAIL restart_done: got %0d, required 1", done_cnt); end
  endtask

  initial begin
    clear_stats();
    test_reset();
    test_oneshot();
    test_backpressure();
    test_continuous();
    test_div1_2();
    test_cfg_change();
    test_back_to_back();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
